// File: rtl/mpu_int_fifo.sv
// rtl/mpu_int_fifo.sv - first-word-fall-through FIFO between MPU user_irq producer and host consumer
// Optional host notification pulse: define MPU_INT_FIFO_HOST_IRQ_EN.
module mpu_int_fifo #(
  parameter int DATA_WIDTH = 64,
  parameter int DEPTH_LOG2 = 3
) (
  input  logic                  sys_clk,
  input  logic                  sys_rst,
  input  logic                  irq,
  input  logic [DATA_WIDTH-1:0] data,
  output logic                  en,
  input  logic                  pop,
  output logic [DATA_WIDTH-1:0] q,
  output logic                  valid,
  output logic [DEPTH_LOG2:0]   level,
  input  logic                  ovf_clr,
  output logic                  overflow,
  output logic                  host_irq
);

  localparam int DEPTH = 1 << DEPTH_LOG2;
  localparam logic [DEPTH_LOG2:0] FULL_LEVEL = (DEPTH_LOG2 + 1)'(DEPTH);

  logic [DATA_WIDTH-1:0] mem [DEPTH];
  logic [DEPTH_LOG2-1:0] wr_ptr;
  logic [DEPTH_LOG2-1:0] rd_ptr;
  logic [DEPTH_LOG2:0]   level_nxt;
  logic                  ovf_nxt;
  logic                  do_push;
  logic                  do_pop;
  logic                  drop;

  assign en      = (level != FULL_LEVEL);
  assign valid   = (level != '0);
  assign q       = valid ? mem[rd_ptr] : '0;
  assign do_push = irq & en;
  assign do_pop  = pop & valid;
  assign drop    = irq & ~en;

  always_comb begin
    level_nxt = level;
    case ({do_push, do_pop})
      2'b10:   level_nxt = level + 1'b1;
      2'b01:   level_nxt = level - 1'b1;
      default: level_nxt = level;
    endcase
  end

  // A drop in the same cycle as ovf_clr keeps the flag set.
  always_comb begin
    ovf_nxt = overflow;
    if (drop)
      ovf_nxt = 1'b1;
    else if (ovf_clr)
      ovf_nxt = 1'b0;
  end

  always_ff @(posedge sys_clk) begin
    if (sys_rst) begin
      wr_ptr   <= '0;
      rd_ptr   <= '0;
      level    <= '0;
      overflow <= 1'b0;
    end else begin
      if (do_push)
        wr_ptr <= wr_ptr + 1'b1;
      if (do_pop)
        rd_ptr <= rd_ptr + 1'b1;
      level    <= level_nxt;
      overflow <= ovf_nxt;
    end
  end

  // Storage is not reset; a push never targets the head slot while it is occupied.
  always_ff @(posedge sys_clk) begin
    if (!sys_rst && do_push)
      mem[wr_ptr] <= data;
  end

`ifdef MPU_INT_FIFO_HOST_IRQ_EN
  logic host_irq_q;

  always_ff @(posedge sys_clk) begin
    if (sys_rst)
      host_irq_q <= 1'b0;
    else
      host_irq_q <= ((level == '0) && (level_nxt != '0)) || (!overflow && ovf_nxt);
  end

  assign host_irq = host_irq_q;
`else
  assign host_irq = 1'b0;
`endif

endmodule

// File: tb/tb_mpu_int_fifo.sv
// tb/tb_mpu_int_fifo.sv - randomized and directed bench for mpu_int_fifo against a queue model
module tb_mpu_int_fifo;

  localparam int DW = 64;
  localparam int DL = 2;
`ifdef MPU_INT_FIFO_HOST_IRQ_EN
  localparam bit HIRQ = 1'b1;
`else
  localparam bit HIRQ = 1'b0;
`endif

  logic          sys_clk = 1'b0;
  logic          sys_rst = 1'b1;
  logic          irq = 1'b0;
  logic [DW-1:0] data = '0;
  logic          en;
  logic          pop = 1'b0;
  logic [DW-1:0] q;
  logic          valid;
  logic [DL:0]   level;
  logic          ovf_clr = 1'b0;
  logic          overflow;
  logic          host_irq;

  int passed = 0;
  int total  = 0;

  logic [DW-1:0] m_q[$];
  bit            m_ovf  = 1'b0;
  bit            m_hirq = 1'b0;

  mpu_int_fifo #(.DATA_WIDTH(DW), .DEPTH_LOG2(DL)) dut (
    .sys_clk  (sys_clk),
    .sys_rst  (sys_rst),
    .irq      (irq),
    .data     (data),
    .en       (en),
    .pop      (pop),
    .q        (q),
    .valid    (valid),
    .level    (level),
    .ovf_clr  (ovf_clr),
    .overflow (overflow),
    .host_irq (host_irq)
  );

  always #5 sys_clk = ~sys_clk;

  // One clock of stimulus; the model follows the FIFO rules on the queue, outputs sampled 1 unit after the edge.
  task automatic cycle(input bit i_irq, input logic [DW-1:0] d, input bit i_pop, input bit clr, input bit r);
    bit was_empty, full, new_ovf;
    irq = i_irq; data = d; pop = i_pop; ovf_clr = clr; sys_rst = r;
    @(posedge sys_clk);
    if (r) begin
      m_q.delete();
      m_ovf  = 1'b0;
      m_hirq = 1'b0;
    end else begin
      was_empty = (m_q.size() == 0);
      full      = (m_q.size() == (1 << DL));
      if (i_pop && !was_empty) void'(m_q.pop_front());
      if (i_irq && !full) m_q.push_back(d);
      new_ovf = (i_irq && full) ? 1'b1 : (clr ? 1'b0 : m_ovf);
      m_hirq  = HIRQ && ((was_empty && m_q.size() != 0) || (!m_ovf && new_ovf));
      m_ovf   = new_ovf;
    end
    #1;
    irq = 1'b0; pop = 1'b0; ovf_clr = 1'b0; sys_rst = 1'b0;
  endtask

  task automatic test_reset();
    cycle(0, '0, 0, 0, 1);
    cycle(1, 64'h55, 1, 1, 1);
    total++;
    if ({en, valid, level, overflow, host_irq} !== {1'b1, 1'b0, 3'd0, 1'b0, 1'b0}) begin
      $display("FAIL reset_flags: got en/valid/level/ovf/hirq=%b expected %b", {en, valid, level, overflow, host_irq}, 7'b1000000);
    end else passed++;
    total++;
    if (q !== '0) $display("FAIL reset_q: got %h expected 0", q); else passed++;
  endtask

  task automatic test_single();
    cycle(1, 64'h11, 0, 0, 0);
    total++;
    if ({valid, level, host_irq} !== {1'b1, 3'd1, HIRQ}) begin
      $display("FAIL single_push: got valid/level/hirq=%b expected %b", {valid, level, host_irq}, {1'b1, 3'd1, HIRQ});
    end else passed++;
    total++;
    if (q !== 64'h11) $display("FAIL single_q: got %h expected 11", q); else passed++;
    cycle(0, '0, 0, 0, 0);
    total++;
    if (host_irq !== 1'b0) $display("FAIL single_hirq_once: got %b expected 0", host_irq); else passed++;
    cycle(0, '0, 1, 0, 0);
    total++;
    if ({valid, level} !== {1'b0, 3'd0}) $display("FAIL single_drain: got %b expected 0000", {valid, level}); else passed++;
  endtask

  task automatic test_fill_overflow();
    for (int i = 1; i <= 4; i++) begin
      cycle(1, DW'(i), 0, 0, 0);
      total++;
      if (level !== 3'(i)) $display("FAIL fill_level_%0d: got %0d expected %0d", i, level, i); else passed++;
    end
    total++;
    if (en !== 1'b0) $display("FAIL fill_en: got %b expected 0", en); else passed++;
    cycle(1, 64'h5, 0, 0, 0);
    total++;
    if ({overflow, level, host_irq} !== {1'b1, 3'd4, HIRQ}) begin
      $display("FAIL fill_drop: got ovf/level/hirq=%b expected %b", {overflow, level, host_irq}, {1'b1, 3'd4, HIRQ});
    end else passed++;
    cycle(0, '0, 0, 1, 0);
    for (int i = 1; i <= 4; i++) begin
      total++;
      if (q !== DW'(i)) $display("FAIL fill_pop_%0d: got %h expected %h", i, q, DW'(i)); else passed++;
      cycle(0, '0, 1, 0, 0);
    end
    total++;
    if ({valid, q} !== {1'b0, 64'h0}) $display("FAIL fill_empty: got valid=%b q=%h expected valid=0 q=0", valid, q); else passed++;
  endtask

  task automatic test_back_to_back();
    logic [DW-1:0] order [8];
    order[0] = 64'h10; order[1] = 64'h20;
    for (int k = 0; k < 6; k++) order[k+2] = 64'hA0 + DW'(k);
    cycle(1, order[0], 0, 0, 0);
    cycle(1, order[1], 0, 0, 0);
    for (int k = 0; k < 6; k++) begin
      total++;
      if (q !== order[k]) $display("FAIL b2b_q_%0d: got %h expected %h", k, q, order[k]); else passed++;
      cycle(1, order[k+2], 1, 0, 0);
      total++;
      if (level !== 3'd2) $display("FAIL b2b_level_%0d: got %0d expected 2", k, level); else passed++;
    end
    for (int k = 6; k < 8; k++) begin
      total++;
      if (q !== order[k]) $display("FAIL b2b_tail_%0d: got %h expected %h", k, q, order[k]); else passed++;
      cycle(0, '0, 1, 0, 0);
    end
  endtask

  task automatic test_empty_pop();
    cycle(0, '0, 1, 0, 0);
    total++;
    if ({valid, level} !== {1'b0, 3'd0}) $display("FAIL empty_pop: got %b expected 0000", {valid, level}); else passed++;
    cycle(1, 64'h77, 1, 0, 0);
    total++;
    if ({level, q} !== {3'd1, 64'h77}) $display("FAIL empty_push_pop: got level=%0d q=%h expected level=1 q=77", level, q); else passed++;
    cycle(0, '0, 1, 0, 0);
  endtask

  task automatic test_full_pop_drop();
    for (int i = 0; i < 4; i++) cycle(1, 64'hB0 + DW'(i), 0, 0, 0);
    cycle(1, 64'hBF, 1, 0, 0);
    total++;
    if ({level, overflow} !== {3'd3, 1'b1}) $display("FAIL full_pop_drop: got level=%0d ovf=%b expected level=3 ovf=1", level, overflow); else passed++;
    total++;
    if (q !== 64'hB1) $display("FAIL full_pop_head: got %h expected b1", q); else passed++;
    cycle(1, 64'hC0, 0, 0, 0);
    cycle(1, 64'hCF, 0, 1, 0);
    total++;
    if ({level, overflow} !== {3'd4, 1'b1}) $display("FAIL clr_vs_drop: got level=%0d ovf=%b expected level=4 ovf=1", level, overflow); else passed++;
    cycle(0, '0, 0, 1, 0);
    total++;
    if (overflow !== 1'b0) $display("FAIL clr_alone: got %b expected 0", overflow); else passed++;
    for (int i = 0; i < 4; i++) cycle(0, '0, 1, 0, 0);
  endtask

  task automatic test_reset_midstream();
    for (int i = 0; i < 5; i++) cycle(1, 64'hD0 + DW'(i), 0, 0, 0);
    cycle(0, '0, 1, 0, 0);
    cycle(1, 64'hEE, 0, 0, 1);
    total++;
    if ({level, valid, en, overflow, host_irq} !== {3'd0, 1'b0, 1'b1, 1'b0, 1'b0}) begin
      $display("FAIL reset_mid: got level/valid/en/ovf/hirq=%b expected 0000100", {level, valid, en, overflow, host_irq});
    end else passed++;
  endtask

  task automatic test_random();
    logic [DW-1:0] e_q;
    for (int n = 0; n < 500; n++) begin
      cycle(1'($urandom_range(0, 1)), {$urandom, $urandom}, ($urandom_range(0, 99) < 45),
            ($urandom_range(0, 99) < 6), ($urandom_range(0, 99) < 2));
      e_q = (m_q.size() != 0) ? m_q[0] : '0;
      total++;
      if ({en, valid, level, overflow, host_irq} !==
          {(m_q.size() != 4), (m_q.size() != 0), 3'(m_q.size()), m_ovf, m_hirq}) begin
        $display("FAIL rand_flags_%0d: got en/valid/level/ovf/hirq=%b expected %b", n,
                 {en, valid, level, overflow, host_irq},
                 {(m_q.size() != 4), (m_q.size() != 0), 3'(m_q.size()), m_ovf, m_hirq});
      end else passed++;
      total++;
      if (q !== e_q) $display("FAIL rand_q_%0d: got %h expected %h", n, q, e_q); else passed++;
    end
  endtask

  initial begin
    test_reset();
    test_single();
    test_fill_overflow();
    test_back_to_back();
    test_empty_pop();
    test_full_pop_drop();
    test_reset_midstream();
    test_random();
    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

endmodule

// File: doc/mpu_int_fifo.md
MPU_INT_FIFO -- requirements
Module: mpu_int_fifo

Interface
REQ-001 The block SHALL have parameter DATA_WIDTH, default 64, giving the width of the user data word.
REQ-002 The block SHALL have parameter DEPTH_LOG2, default 3, giving a FIFO depth of DEPTH = 2**DEPTH_LOG2 entries.
REQ-003 The block SHALL have port sys_clk, input, 1 bit: the single clock; all logic on its rising edge.
REQ-004 The block SHALL have port sys_rst, input, 1 bit: synchronous, active-high reset.
REQ-005 The block SHALL have port irq, input, 1 bit: the producer (MPU user_irq) presents a word this cycle.
REQ-006 The block SHALL have port data, input, DATA_WIDTH bits: the producer word, sampled when irq=1.
REQ-007 The block SHALL have port en, output, 1 bit: space available; the producer stalls while en=0.
REQ-008 The block SHALL have port pop, input, 1 bit: the consumer takes the head word this cycle.
REQ-009 The block SHALL have port q, output, DATA_WIDTH bits: the head word (first-word-fall-through).
REQ-010 The block SHALL have port valid, output, 1 bit: FIFO non-empty.
REQ-011 The block SHALL have port level, output, DEPTH_LOG2+1 bits: current occupancy, 0..DEPTH.
REQ-012 The block SHALL have port ovf_clr, input, 1 bit: clears the overflow flag.
REQ-013 The block SHALL have port overflow, output, 1 bit: sticky flag, set when a word was dropped.
REQ-014 The block SHALL have port host_irq, output, 1 bit: host notification pulse (see REQ-030).

Function
REQ-015 en SHALL equal (level != DEPTH), derived combinationally from registered state.
REQ-016 valid SHALL equal (level != 0); q SHALL be mem[rd_ptr] when valid=1 and all-zero when valid=0.
REQ-017 A push SHALL occur on a clock edge where irq=1 and en=1: mem[wr_ptr] <= data, and wr_ptr increments.
REQ-018 A pop SHALL occur on a clock edge where pop=1 and valid=1: rd_ptr increments; the new head is visible on q the following cycle.
REQ-019 Push-to-q latency SHALL be one cycle: a word pushed into an empty FIFO appears on q, with valid=1, in the next cycle.
REQ-020 wr_ptr and rd_ptr SHALL be DEPTH_LOG2 bits wide and wrap modulo DEPTH with no extra logic.
REQ-021 level SHALL increment on a push without a pop, decrement on a pop without a push, and hold on both or neither.
REQ-022 With push and pop in the same cycle and 0<level<DEPTH, both SHALL occur and level SHALL be unchanged.
REQ-023 When empty, pop SHALL be ignored; simultaneous irq=1 and pop=1 while empty SHALL push only, giving level=1.
REQ-024 When full, irq=1 SHALL drop the word and set overflow, even if pop=1 in the same cycle; the pop still occurs.
REQ-025 overflow SHALL be set by a drop and cleared by ovf_clr=1; if both occur in the same cycle, set SHALL win.
REQ-026 Storage SHALL be a register array; no read-during-write hazard SHALL be visible on q.

Reset
REQ-027 While sys_rst=1 at a clock edge, the block SHALL clear wr_ptr, rd_ptr, level, overflow and host_irq to 0; memory contents are not cleared.
REQ-028 After reset the outputs SHALL read en=1, valid=0, q=0, level=0, overflow=0, host_irq=0.
REQ-029 Reset SHALL override any simultaneous irq, pop or ovf_clr; words in flight SHALL be discarded without setting overflow.

Configuration
REQ-030 When macro MPU_INT_FIFO_HOST_IRQ_EN is defined, host_irq SHALL be a registered one-cycle pulse on the cycle after level goes from 0 to nonzero or overflow goes from 0 to 1.
REQ-031 When MPU_INT_FIFO_HOST_IRQ_EN is undefined, host_irq SHALL be constant 0 and its generation logic SHALL be absent.

Verification (bench with DEPTH_LOG2=2, DATA_WIDTH=64)
REQ-032 Reset, then irq=1 with data=0x11 for one cycle -> next cycle valid=1, q=0x11, level=1; with the macro defined, host_irq pulses once.
REQ-033 Push 0x1..0x4 on consecutive cycles -> level=4, en=0; a fifth irq with 0x5 -> overflow=1, level stays 4; pop 4 times -> q reads 0x1,0x2,0x3,0x4, then valid=0, q=0.
REQ-034 At level=2, irq=1 and pop=1 for 6 cycles with data 0xA0..0xA5 -> level stays 2, pops return stored order, pointers wrap past 3->0 correctly.
REQ-035 Empty FIFO, pop=1 alone -> level stays 0; irq=1 with pop=1 and data=0x77 -> level=1, q=0x77.
REQ-036 Full FIFO with irq=1 and pop=1 -> head popped, word dropped, level=3, overflow=1; ovf_clr=1 together with a new drop -> overflow stays 1; ovf_clr alone -> overflow=0.
REQ-037 At level=3, assert sys_rst for 1 cycle while irq=1 -> level=0, valid=0, en=1, overflow=0, host_irq=0.
